// File: rtl/gcd_result_unloader.sv
// ============================================================================
// Module      : gcd_result_unloader
// Description : Accepts finished GCD results and serialises each one into a
//               framed byte stream (header = sequence number, data MSB first).
//               Optional macro GCD_UNLOAD_CSUM_EN appends an XOR checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_result_unloader #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         result_rdy,
    input  logic [W-1:0] result_bits,
    output logic         result_taken,
    output logic         out_valid,
    output logic [7:0]   out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy,
    output logic [7:0]   seq
);

    localparam int NB = (W + 7) / 8;
`ifdef GCD_UNLOAD_CSUM_EN
    localparam int FLEN = NB + 2;
`else
    localparam int FLEN = NB + 1;
`endif
    localparam int IW = $clog2(FLEN);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t            r_state;
    logic [NB*8-1:0]   r_cap;
    logic [IW-1:0]     r_idx;
    logic              r_valid;
    logic [7:0]        r_data;
    logic              r_last;
    logic              r_busy;
    logic [7:0]        r_seq;
`ifdef GCD_UNLOAD_CSUM_EN
    logic [7:0]        r_hdr;
    logic [7:0]        w_csum;
`endif

    logic [NB*8-1:0]   w_ext;
    logic [IW-1:0]     w_nidx;
    logic [7:0]        w_next_byte;
    logic              w_next_last;

    assign result_taken = (r_state == S_IDLE) && result_rdy && reset;

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_last  = r_last;
    assign busy      = r_busy;
    assign seq       = r_seq;

    // Byte that follows the one currently presented (index r_idx + 1).
    always_comb begin
        w_ext          = '0;
        w_ext[W-1:0]   = result_bits;
        w_nidx         = r_idx + IW'(1);
        w_next_byte    = 8'h00;
        for (int k = 1; k <= NB; k++) begin
            if (w_nidx == IW'(k)) begin
                w_next_byte = r_cap[(NB-k)*8 +: 8];
            end
        end
`ifdef GCD_UNLOAD_CSUM_EN
        w_csum = r_hdr;
        for (int k = 0; k < NB; k++) begin
            w_csum = w_csum ^ r_cap[k*8 +: 8];
        end
        if (w_nidx == IW'(NB + 1)) begin
            w_next_byte = w_csum;
        end
`endif
        w_next_last = (w_nidx == IW'(FLEN - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cap   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_data  <= 8'h00;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_seq   <= 8'h00;
`ifdef GCD_UNLOAD_CSUM_EN
            r_hdr   <= 8'h00;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (result_rdy) begin
                        r_cap   <= w_ext;
                        r_idx   <= '0;
                        r_data  <= r_seq;
                        r_last  <= 1'b0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_seq   <= r_seq + 8'd1;
`ifdef GCD_UNLOAD_CSUM_EN
                        r_hdr   <= r_seq;
`endif
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    // out_valid is always high here, so out_ready alone means a transfer.
                    if (out_ready) begin
                        if (r_last) begin
                            r_state <= S_IDLE;
                            r_idx   <= '0;
                            r_valid <= 1'b0;
                            r_data  <= 8'h00;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx   <= w_nidx;
                            r_data  <= w_next_byte;
                            r_last  <= w_next_last;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gcd_result_unloader.sv
// Randomised bench for gcd_result_unloader: a frame-queue reference model
// predicts every output each cycle; a W=9 instance covers the odd width.
`default_nettype none

module tb_gcd_result_unloader;

    localparam int W    = 16;
    localparam int NB   = (W + 7) / 8;
    localparam int W9   = 9;
    localparam int NB9  = (W9 + 7) / 8;
`ifdef GCD_UNLOAD_CSUM_EN
    localparam int CS   = 1;
`else
    localparam int CS   = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rdy = 1'b0;
    logic [W-1:0]  bits = '0;
    logic          taken;
    logic          vld;
    logic [7:0]    data;
    logic          last;
    logic          ordy = 1'b0;
    logic          bsy;
    logic [7:0]    sq;

    logic          rst9_n = 1'b0;
    logic          rdy9 = 1'b0;
    logic [W9-1:0] bits9 = '0;
    logic          taken9;
    logic          vld9;
    logic [7:0]    data9;
    logic          last9;
    logic          ordy9 = 1'b0;
    logic          bsy9;
    logic [7:0]    sq9;

    always #5 clk = ~clk;

    gcd_result_unloader #(.W(W)) dut (
        .clk(clk), .reset(rst_n), .result_rdy(rdy), .result_bits(bits),
        .result_taken(taken), .out_valid(vld), .out_data(data), .out_last(last),
        .out_ready(ordy), .busy(bsy), .seq(sq)
    );

    gcd_result_unloader #(.W(W9)) dut9 (
        .clk(clk), .reset(rst9_n), .result_rdy(rdy9), .result_bits(bits9),
        .result_taken(taken9), .out_valid(vld9), .out_data(data9), .out_last(last9),
        .out_ready(ordy9), .busy(bsy9), .seq(sq9)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Byte k of a frame: header, data bytes MSB first, then XOR checksum.
    function automatic logic [7:0] frame_byte(input logic [31:0] v, input logic [7:0] s,
                                              input int nb, input int k);
        logic [7:0] cs;
        if (k == 0) return s;
        if (k <= nb) return 8'((v >> (8 * (nb - k))) & 32'hFF);
        cs = s;
        for (int i = 1; i <= nb; i++) cs = cs ^ 8'((v >> (8 * (nb - i))) & 32'hFF);
        return cs;
    endfunction

    // Reference model state
    logic [7:0] exp_q[$];
    bit         m_busy = 1'b0;
    int         m_seq = 0;
    bit         m_after_rst = 1'b1;
    bit         m_took = 1'b0;
    int         m_frames = 0;

    // Stimulus knobs
    int p_rdy = 0, p_ordy = 100, p_rst = 0, stall_cnt = 0, rst_cnt = 0;

    task automatic do_checks();
        check_eq("taken", taken, (!m_busy) && rdy && rst_n);
        check_eq("valid", vld, m_busy);
        check_eq("busy", bsy, m_busy);
        check_eq("seq", sq, m_seq[7:0]);
        if (m_busy) begin
            check_eq("data", data, exp_q[0]);
            check_eq("last", last, exp_q.size() == 1);
        end else if (m_after_rst) begin
            check_eq("rst_data", data, 0);
            check_eq("rst_last", last, 0);
        end
    endtask

    task automatic model_edge();
        m_took = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            m_busy = 1'b0;
            m_seq = 0;
            m_after_rst = 1'b1;
        end else if (!m_busy) begin
            if (rdy) begin
                for (int k = 0; k < NB + 1 + CS; k++)
                    exp_q.push_back(frame_byte(32'(bits), m_seq[7:0], NB, k));
                m_seq = (m_seq + 1) % 256;
                m_busy = 1'b1;
                m_took = 1'b1;
                m_after_rst = 1'b0;
                m_frames++;
            end
        end else if (ordy) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_busy = 1'b0;
        end
    endtask

    task automatic drive();
        if (m_took) rdy = 1'b0;
        if (!rdy && ($urandom_range(99) < p_rdy)) begin
            rdy = 1'b1;
            bits = W'($urandom);
        end
        if (stall_cnt > 0) begin
            ordy = 1'b0;
            stall_cnt--;
        end else begin
            ordy = ($urandom_range(99) < p_ordy);
        end
        if (rst_cnt > 0) begin
            rst_n = 1'b0;
            rst_cnt--;
        end else begin
            rst_n = !(p_rst != 0 && $urandom_range(999) < p_rst);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        do_checks();
        @(posedge clk);
        model_edge();
        #1;
        drive();
    endtask

    logic [7:0] got9[$];
    logic       gotl9[$];

    initial begin
        // Reset
        rst_cnt = 3;
        @(posedge clk);
        model_edge();
        #1;
        drive();
        repeat (4) cycle();

        // Basic frame 0x0006
        rdy = 1'b1; bits = 16'h0006;
        repeat (8) cycle();

        // Second frame 0x1234 with a 5-cycle stall mid-frame
        rdy = 1'b1; bits = 16'h1234;
        repeat (3) cycle();
        stall_cnt = 5;
        repeat (12) cycle();

        // Result pending during SEND, random backpressure
        p_rdy = 100; p_ordy = 60;
        repeat (60) cycle();

        // Sequence wrap: keep results flowing until past 257 frames
        p_ordy = 100;
        for (int i = 0; i < 3000 && m_frames < 262; i++) cycle();

        // Reset during data byte 1, with a result pending
        p_rdy = 0;
        for (int i = 0; i < 30 && m_busy; i++) cycle();
        rdy = 1'b1; bits = 16'hA5C3;
        for (int i = 0; i < 20 && !(m_busy && exp_q.size() == NB + CS); i++) cycle();
        rdy = 1'b1;
        rst_cnt = 2;
        repeat (5) cycle();

        // Random mix including occasional resets
        p_rdy = 30; p_ordy = 70; p_rst = 5;
        repeat (2000) cycle();
        p_rst = 0;
        repeat (5) cycle();

        // Odd width W=9 with result 0x1FF
        @(negedge clk);
        rdy9 = 1'b1;
        check_eq("w9_taken_in_rst", taken9, 0);
        @(posedge clk);
        #1;
        rst9_n = 1'b1; ordy9 = 1'b1; bits9 = 9'h1FF;
        @(negedge clk);
        check_eq("w9_taken", taken9, 1);
        @(posedge clk);
        #1;
        rdy9 = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (vld9) begin
                got9.push_back(data9);
                gotl9.push_back(last9);
            end
        end
        check_eq("w9_len", got9.size(), NB9 + 1 + CS);
        for (int k = 0; k < got9.size() && k < NB9 + 1 + CS; k++) begin
            check_eq("w9_byte", got9[k], frame_byte(32'h1FF, 8'h00, NB9, k));
            check_eq("w9_last", gotl9[k], k == NB9 + CS);
        end
        check_eq("w9_seq", sq9, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gcd_result_unloader.md
Name: gcd_result_unloader

Overview:
Downstream neighbour of the GCD control unit and datapath. Consumes the finished GCD result using the result_rdy/result_taken handshake and frees the GCD unit for the next operand pair. Serialises each result into a framed byte stream with valid/ready flow control, which feeds the team's byte-oriented output path (UART/IO bridge).

Parameters:
W, 16, width of the GCD result; legal range 1..32.
NB, (W+7)/8, number of data bytes per frame. Derived localparam, not overridable.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-low reset; 0 = reset, sampled on the rising edge of clk.
result_rdy  input  1  from the GCD control unit; result_bits is valid while this is high.
result_bits  input  W  GCD result from the datapath.
result_taken  output  1  to the GCD control unit; 1-cycle acknowledge.
out_valid  output  1  byte-stream valid.
out_data  output  8  byte-stream data.
out_last  output  1  high on the final byte of a frame.
out_ready  input  1  downstream ready.
busy  output  1  high while a frame is in flight (state SEND).
seq  output  8  sequence number that the next captured result will carry.

Behaviour:
- FSM states: IDLE and SEND.
- Reset (reset=0 at a clk edge):
  - state=IDLE; out_valid=0; out_last=0; out_data=0; busy=0; seq=0.
  - The capture register and byte index are cleared.
  - result_taken is forced to 0 in every cycle where reset=0.
- result_taken:
  - Combinational: result_taken = (state==IDLE) && result_rdy && reset.
  - Capture happens on the same edge: result_bits is zero-extended to NB*8 bits and latched, the current seq is latched as the frame header, seq is incremented (8-bit wrap, 255 -> 0), and the FSM moves IDLE -> SEND.
  - The GCD control unit leaves its DONE state on that edge, so result_taken is high for exactly one cycle per result. A double capture is impossible.
- Frame format, NB+1 bytes:
  - Byte 0: header = latched seq.
  - Bytes 1..NB: data, most significant byte first.
  - out_last=1 on the final byte only.
- SEND state:
  - out_valid=1 from the first cycle after capture, so the header appears 1 cycle after result_taken.
  - A byte transfers on an edge where out_valid && out_ready; the byte index then advances.
  - While out_valid && !out_ready, out_data and out_last hold stable and out_valid stays 1.
- End of frame:
  - On the transfer of the last byte, the FSM returns to IDLE and out_valid drops the next cycle.
  - In that IDLE cycle a new result can be captured if result_rdy=1.
  - Minimum spacing between captures: NB+2 cycles with out_ready tied high (NB+3 when GCD_UNLOAD_CSUM_EN is defined).
- result_rdy handling:
  - result_rdy is ignored in SEND; the GCD unit is stalled in DONE until the frame finishes.
  - If result_rdy rises during SEND, the capture occurs in the first IDLE cycle.
- Reset mid-frame: the frame is abandoned with no out_last, and out_valid=0 after the reset edge. Downstream must tolerate a truncated frame after reset.
- Outputs out_valid, out_data, out_last, busy and seq are registered. Only result_taken is combinational.

Optional Feature:
GCD_UNLOAD_CSUM_EN:
- Defined: one extra trailing byte equal to the XOR of the header and all NB data bytes. out_last moves to this checksum byte; frame length is NB+2.
- Undefined: no checksum logic is present; frame length is NB+1 and out_last is on the last data byte.

Test Plan:
1. Basic frame (W=16, checksum off):
   - Stimulus: reset released; result_rdy=1 with result_bits=0x0006; out_ready=1.
   - Response: result_taken high for exactly 1 cycle. Next cycles emit 0x00 (header), 0x00, 0x06 with out_last on 0x06. busy drops after the frame; seq=1.
2. Checksum (W=16, GCD_UNLOAD_CSUM_EN defined):
   - Stimulus: second result 0x1234 with seq=1.
   - Response: bytes 0x01, 0x12, 0x34, 0x27; out_last on 0x27.
3. Backpressure:
   - Stimulus: out_ready held low for 5 cycles mid-frame.
   - Response: out_valid stays 1 and out_data/out_last are stable during the stall; no byte is lost or repeated.
4. Result during SEND:
   - Stimulus: result_rdy held high during SEND.
   - Response: result_taken stays 0 until the IDLE cycle after the last byte; the next header is the incremented seq.
5. Sequence wrap:
   - Stimulus: 257 results.
   - Response: the headers of frames 256 and 257 are 0xFF and 0x00.
6. Reset mid-frame and odd width:
   - Stimulus: reset=0 during data byte 1.
   - Response: out_valid=0 next cycle, seq=0, and result_taken=0 while reset=0.
   - Also, with W=9 and result 0x1FF: data bytes 0x01, 0xFF.
